// File: rtl/im_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : im_arbiter
// Purpose  : Fetch/loader arbiter for a single-port instruction memory
//            with bounded loader starvation and a fetch-blocking lock mode.
// Revision : 1.0 - initial release
// ============================================================================
module im_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_lock,
  output logic          ld_gnt,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t        r_state;
  logic [3:0]    r_starve;
  logic          r_if_pend;
  logic          r_ld_pend;
  logic          r_ld_rd;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_ld_rdata;

  logic          w_starved;
  logic          w_if_arb;
  logic          w_ld_arb;

  assign w_starved = (r_starve == c_STARVE_MAX);

  always_comb begin
    w_if_arb = 1'b0;
    w_ld_arb = 1'b0;
    if (r_state == ST_LOCK) begin
      w_ld_arb = ld_req;
    end else begin
      w_ld_arb = ld_req & (~if_req | w_starved);
      w_if_arb = if_req & ~w_ld_arb;
    end
  end

  // Grants are masked while reset is held so nothing reaches the memory.
  assign if_gnt    = w_if_arb & rst_n;
  assign ld_gnt    = w_ld_arb & rst_n;
  assign if_stall  = if_req & ~if_gnt;

  assign mem_we    = ld_gnt & ld_we;
  assign mem_addr  = ld_gnt ? ld_addr : (if_gnt ? if_addr : r_addr);
  assign mem_wdata = ld_gnt ? ld_wdata : r_wdata;

  assign if_valid  = r_if_pend;
  assign ld_ack    = r_ld_pend;
  assign if_rdata  = r_if_pend ? mem_rdata : r_if_rdata;
  assign ld_rdata  = (r_ld_pend & r_ld_rd) ? mem_rdata : r_ld_rdata;
  assign locked    = (r_state == ST_LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_starve   <= 4'd0;
      r_if_pend  <= 1'b0;
      r_ld_pend  <= 1'b0;
      r_ld_rd    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_ld_rdata <= '0;
    end else begin
      case (r_state)
        ST_RUN:  if (ld_lock)  r_state <= ST_LOCK;
        ST_LOCK: if (!ld_lock) r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase

      if (!ld_req || w_ld_arb) begin
        r_starve <= 4'd0;
      end else if (!w_starved) begin
        r_starve <= r_starve + 4'd1;
      end

      r_if_pend <= w_if_arb;
      r_ld_pend <= w_ld_arb;
      r_ld_rd   <= w_ld_arb & ~ld_we;

      if (w_ld_arb) begin
        r_addr  <= ld_addr;
        r_wdata <= ld_wdata;
      end else if (w_if_arb) begin
        r_addr  <= if_addr;
      end

      // Keep the last delivered word so the idle rdata output holds steady.
      if (r_if_pend)            r_if_rdata <= mem_rdata;
      if (r_ld_pend && r_ld_rd) r_ld_rdata <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_im_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_arbiter
// Purpose  : Directed and mixed-traffic bench for im_arbiter against a
//            rule-level reference model and an attached synchronous RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_valid, if_stall;
  logic [DW-1:0] if_rdata;
  logic          ld_req, ld_we, ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt, ld_ack;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          locked;

  int n_checks = 0;
  int n_errors = 0;

  im_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT and the reference copy the model owns.
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA5000000 + 32'(i * 3);
      ref_mem[i] = 32'hA5000000 + 32'(i * 3);
    end
    mem[0]     = 32'h37180000;
    ref_mem[0] = 32'h37180000;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grants from the arbitration rules, responses as a
  // one-deep pipeline of (port, data) captured from the reference memory.
  int            m_lost = 0;
  bit            m_locked = 0;
  bit            m_if_pend = 0, m_ld_pend = 0, m_ld_rd = 0;
  logic [DW-1:0] m_if_data = '0, m_ld_data = '0, m_if_last = '0, m_ld_last = '0;
  logic [DW-1:0] m_last_wdata = '0;
  logic [AW-1:0] m_last_addr = '0;
  bit            eg_if, eg_ld;
  logic [AW-1:0] e_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("m_rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("m_rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
      chk("m_rst_valid",  {30'd0, if_valid, ld_ack}, 32'd0);
      chk("m_rst_we",     {30'd0, mem_we, locked}, 32'd0);
      chk("m_rst_if_rd",  if_rdata, 32'd0);
      chk("m_rst_ld_rd",  ld_rdata, 32'd0);
      chk("m_rst_addr",   {22'd0, mem_addr}, 32'd0);
      chk("m_rst_wdata",  mem_wdata, 32'd0);
      m_lost = 0; m_locked = 0; m_if_pend = 0; m_ld_pend = 0; m_ld_rd = 0;
      m_if_last = '0; m_ld_last = '0; m_last_addr = '0; m_last_wdata = '0;
    end else begin
      if (m_locked) begin
        eg_ld = ld_req;
        eg_if = 1'b0;
      end else begin
        eg_ld = ld_req && (!if_req || m_lost >= SM);
        eg_if = if_req && !eg_ld;
      end
      e_addr = eg_ld ? ld_addr : (eg_if ? if_addr : m_last_addr);

      chk("m_if_gnt",   {31'd0, if_gnt},   {31'd0, eg_if});
      chk("m_ld_gnt",   {31'd0, ld_gnt},   {31'd0, eg_ld});
      chk("m_if_stall", {31'd0, if_stall}, {31'd0, if_req && !eg_if});
      chk("m_mem_we",   {31'd0, mem_we},   {31'd0, eg_ld && ld_we});
      chk("m_mem_addr", {22'd0, mem_addr}, {22'd0, e_addr});
      if (eg_ld && ld_we) chk("m_mem_wdata", mem_wdata, ld_wdata);
      chk("m_locked",   {31'd0, locked},   {31'd0, m_locked});
      chk("m_if_valid", {31'd0, if_valid}, {31'd0, m_if_pend});
      chk("m_ld_ack",   {31'd0, ld_ack},   {31'd0, m_ld_pend});
      chk("m_if_rdata", if_rdata, m_if_pend ? m_if_data : m_if_last);
      chk("m_ld_rdata", ld_rdata, (m_ld_pend && m_ld_rd) ? m_ld_data : m_ld_last);

      if (m_if_pend) m_if_last = m_if_data;
      if (m_ld_pend && m_ld_rd) m_ld_last = m_ld_data;
      m_if_pend = eg_if;
      m_ld_pend = eg_ld;
      m_ld_rd   = eg_ld && !ld_we;
      if (eg_if) m_if_data = ref_mem[if_addr];
      if (eg_ld && !ld_we) m_ld_data = ref_mem[ld_addr];
      if (eg_ld && ld_we) begin
        ref_mem[ld_addr] = ld_wdata;
        m_last_wdata = ld_wdata;
      end
      m_last_addr = e_addr;
      m_lost   = (ld_req && !eg_ld) ? ((m_lost + 1 > SM) ? SM : m_lost + 1) : 0;
      m_locked = ld_lock;
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  bit g_if, g_ld;

  initial begin
    rst_n = 1'b0; if_req = 1'b1; if_addr = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_lock = 1'b0;

    // Reset held with a pending fetch, then first fetch after release.
    repeat (3) @(negedge clk);
    chk("rst_no_gnt", {31'd0, if_gnt}, 32'd0);
    drive_edge(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_gnt", {31'd0, if_gnt}, 32'd1);
    drive_edge(); if_req = 1'b0;
    @(negedge clk);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd1);
    chk("rst_if_rdata", if_rdata, 32'h37180000);

    // Continuous fetch with a starving loader read of word 5.
    drive_edge(); if_req = 1'b1; if_addr = '0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'h005;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("starve_if_gnt", {31'd0, if_gnt}, {31'd0, c != 5});
      chk("starve_ld_gnt", {31'd0, ld_gnt}, {31'd0, c == 5});
      if (c == 6) begin
        chk("starve_ld_ack",   {31'd0, ld_ack}, 32'd1);
        chk("starve_ld_rdata", ld_rdata, 32'hA500000F);
      end
      g_if = if_gnt; g_ld = ld_gnt;
      drive_edge();
      if (g_if) if_addr = if_addr + 10'd1;
      if (g_ld) ld_req = 1'b0;
    end

    // Lock with a fetch in flight, loader download, then unlock and fetch.
    if_req = 1'b1; if_addr = 10'h003; ld_lock = 1'b1;
    @(negedge clk);
    chk("lock_last_run_gnt", {31'd0, if_gnt}, 32'd1);
    drive_edge(); if_addr = 10'h00A;
    @(negedge clk);
    chk("lock_locked",   {31'd0, locked},   32'd1);
    chk("lock_if_gnt",   {31'd0, if_gnt},   32'd0);
    chk("lock_if_stall", {31'd0, if_stall}, 32'd1);
    chk("lock_inflight", if_rdata, 32'hA5000009);
    drive_edge(); ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'h00A; ld_wdata = 32'h01896020;
    @(negedge clk);
    chk("lock_ld_wr_gnt", {31'd0, ld_gnt, mem_we}, 32'd3);
    drive_edge(); ld_req = 1'b0; ld_lock = 1'b0;
    @(negedge clk);
    chk("lock_wr_ack", {31'd0, ld_ack}, 32'd1);
    drive_edge();
    @(negedge clk);
    chk("unlock_if_gnt", {30'd0, locked, if_gnt}, 32'd1);
    drive_edge(); if_req = 1'b0;
    @(negedge clk);
    chk("unlock_rdata", if_rdata, 32'h01896020);

    // Write to the top word then fetch it on the very next cycle.
    drive_edge(); ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'h3FF; ld_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("raw_we_n", {31'd0, mem_we}, 32'd1);
    drive_edge(); ld_req = 1'b0; ld_we = 1'b0; if_req = 1'b1; if_addr = 10'h3FF;
    @(negedge clk);
    chk("raw_we_n1", {31'd0, mem_we, if_gnt}, 32'd1);
    drive_edge(); if_req = 1'b0;
    @(negedge clk);
    chk("raw_rdata", if_rdata, 32'hDEADBEEF);

    // Reset asserted right after a loader read grant drops the response.
    drive_edge(); ld_req = 1'b1; ld_addr = 10'h007;
    @(negedge clk);
    chk("rstmid_gnt", {31'd0, ld_gnt}, 32'd1);
    drive_edge(); rst_n = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    chk("rstmid_ack", {30'd0, ld_ack, if_valid}, 32'd0);
    chk("rstmid_rdata", ld_rdata | if_rdata, 32'd0);
    drive_edge(); rst_n = 1'b1;

    // Idle: address holds, nothing pulses.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_quiet", {29'd0, mem_we, if_valid, ld_ack}, 32'd0);
      chk("idle_addr", {22'd0, mem_addr}, 32'd0);
    end

    // Mixed traffic on a small address window, model-checked every cycle.
    g_if = 1'b0; g_ld = 1'b0;
    for (int c = 0; c < 200; c++) begin
      drive_edge();
      if (!if_req || g_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 10'($urandom_range(0, 15));
      end
      if (!ld_req || g_ld) begin
        ld_req   = ($urandom_range(0, 2) == 0);
        ld_we    = $urandom_range(0, 1) == 1;
        ld_addr  = 10'($urandom_range(0, 15));
        ld_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) ld_lock = ~ld_lock;
      @(negedge clk);
      g_if = if_gnt; g_ld = ld_gnt;
    end

    drive_edge(); if_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
